// File: rtl/hazard_tracker.sv
// hazard_tracker
// Holds the M and W stage destination records, ages their Tnew each cycle and
// captures load data at the M->W boundary. From the E, M and W records it
// produces the D-stage stall request and forwarded operands for D and E.
// Optional feature: define HAZARD_STAT_EN to add a 32-bit stall_count port.

module hazard_tracker (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  e_regw_adr,
   input  logic [31:0] e_reg_write,
   input  logic [4:0]  e_tnew,
   input  logic [31:0] m_rdata,
   input  logic [4:0]  d_rs,
   input  logic [4:0]  d_rt,
   input  logic [1:0]  d_tuse_rs,
   input  logic [1:0]  d_tuse_rt,
   input  logic [31:0] d_rs_rf,
   input  logic [31:0] d_rt_rf,
   input  logic [4:0]  e_rs,
   input  logic [4:0]  e_rt,
   input  logic [31:0] e_rs_in,
   input  logic [31:0] e_rt_in,
   output logic        stall,
   output logic [31:0] d_rs_val,
   output logic [31:0] d_rt_val,
   output logic [31:0] e_rs_val,
   output logic [31:0] e_rt_val
`ifdef HAZARD_STAT_EN
   ,
   output logic [31:0] stall_count
`endif
);

   logic [4:0]  mAdr_q,  mAdr_d;
   logic [31:0] mData_q, mData_d;
   logic [1:0]  mTnew_q, mTnew_d;
   logic [4:0]  wAdr_q,  wAdr_d;
   logic [31:0] wData_q, wData_d;
   logic [1:0]  eTnew;
   logic [32:0] dRsRes;
   logic [32:0] dRtRes;

   // Returns {stallRequest, value} for one D-stage source; youngest record wins.
   function automatic logic [32:0] dLookup(
      input logic [4:0]  r,
      input logic [1:0]  tuse,
      input logic [31:0] rf,
      input logic [4:0]  eA, input logic [31:0] eD, input logic [1:0] eT,
      input logic [4:0]  mA, input logic [31:0] mD, input logic [1:0] mT,
      input logic [4:0]  wA, input logic [31:0] wD
   );
      logic        hit;
      logic [31:0] data;
      logic [1:0]  tnew;
      logic [32:0] res;
      hit  = 1'b0;
      data = 32'd0;
      tnew = 2'd0;
      res  = {1'b0, rf};
      if (r != 5'd0 && eA == r) begin
         hit = 1'b1; data = eD; tnew = eT;
      end else if (r != 5'd0 && mA == r) begin
         hit = 1'b1; data = mD; tnew = mT;
      end else if (r != 5'd0 && wA == r) begin
         hit = 1'b1; data = wD; tnew = 2'd0;
      end
      if (hit) begin
         if (tnew > tuse) begin
            res = {1'b1, rf};
         end else if (tnew == 2'd0) begin
            res = {1'b0, data};
         end
      end
      return res;
   endfunction

   // Returns the forwarded E-stage operand; a not-yet-ready M match shadows W.
   function automatic logic [31:0] eLookup(
      input logic [4:0]  r,
      input logic [31:0] opIn,
      input logic [4:0]  mA, input logic [31:0] mD, input logic [1:0] mT,
      input logic [4:0]  wA, input logic [31:0] wD
   );
      logic [31:0] res;
      res = opIn;
      if (r != 5'd0 && mA == r) begin
         if (mT == 2'd0) res = mD;
      end else if (r != 5'd0 && wA == r) begin
         res = wD;
      end
      return res;
   endfunction

   // Clamp E Tnew to its legal range, then compute next M and W records.
   always_comb begin
      eTnew   = (e_tnew > 5'd2) ? 2'd2 : e_tnew[1:0];
      mAdr_d  = e_regw_adr;
      mData_d = e_reg_write;
      mTnew_d = (eTnew == 2'd0) ? 2'd0 : eTnew - 2'd1;
      wAdr_d  = mAdr_q;
      wData_d = (mTnew_q == 2'd1) ? m_rdata : mData_q;
   end

   // Advance the M and W records every cycle; stall does not hold them.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mAdr_q  <= 5'd0;
         mData_q <= 32'd0;
         mTnew_q <= 2'd0;
         wAdr_q  <= 5'd0;
         wData_q <= 32'd0;
      end else begin
         mAdr_q  <= mAdr_d;
         mData_q <= mData_d;
         mTnew_q <= mTnew_d;
         wAdr_q  <= wAdr_d;
         wData_q <= wData_d;
      end
   end

   // Resolve D and E operands and the combined stall request.
   always_comb begin
      dRsRes   = dLookup(d_rs, d_tuse_rs, d_rs_rf, e_regw_adr, e_reg_write, eTnew,
                         mAdr_q, mData_q, mTnew_q, wAdr_q, wData_q);
      dRtRes   = dLookup(d_rt, d_tuse_rt, d_rt_rf, e_regw_adr, e_reg_write, eTnew,
                         mAdr_q, mData_q, mTnew_q, wAdr_q, wData_q);
      stall    = dRsRes[32] | dRtRes[32];
      d_rs_val = dRsRes[31:0];
      d_rt_val = dRtRes[31:0];
      e_rs_val = eLookup(e_rs, e_rs_in, mAdr_q, mData_q, mTnew_q, wAdr_q, wData_q);
      e_rt_val = eLookup(e_rt, e_rt_in, mAdr_q, mData_q, mTnew_q, wAdr_q, wData_q);
   end

`ifdef HAZARD_STAT_EN
   logic [31:0] stallCount_q, stallCount_d;

   // Next stall count; wraps naturally at 32 bits.
   always_comb begin
      stallCount_d = stall ? stallCount_q + 32'd1 : stallCount_q;
   end

   // Count cycles in which D was held back.
   always_ff @(posedge clk) begin
      if (!reset) stallCount_q <= 32'd0;
      else        stallCount_q <= stallCount_d;
   end

   assign stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker
// Directed self-checking bench for hazard_tracker. Stall counter checks are
// compiled only when HAZARD_STAT_EN is defined.

module tb_hazard_tracker;

   logic        clk;
   logic        reset;
   logic [4:0]  e_regw_adr;
   logic [31:0] e_reg_write;
   logic [4:0]  e_tnew;
   logic [31:0] m_rdata;
   logic [4:0]  d_rs, d_rt;
   logic [1:0]  d_tuse_rs, d_tuse_rt;
   logic [31:0] d_rs_rf, d_rt_rf;
   logic [4:0]  e_rs, e_rt;
   logic [31:0] e_rs_in, e_rt_in;
   logic        stall;
   logic [31:0] d_rs_val, d_rt_val, e_rs_val, e_rt_val;
`ifdef HAZARD_STAT_EN
   logic [31:0] stall_count;
`endif

   int checkCount = 0;
   int errorCount = 0;

   hazard_tracker dut (
      .clk         (clk),
      .reset       (reset),
      .e_regw_adr  (e_regw_adr),
      .e_reg_write (e_reg_write),
      .e_tnew      (e_tnew),
      .m_rdata     (m_rdata),
      .d_rs        (d_rs),
      .d_rt        (d_rt),
      .d_tuse_rs   (d_tuse_rs),
      .d_tuse_rt   (d_tuse_rt),
      .d_rs_rf     (d_rs_rf),
      .d_rt_rf     (d_rt_rf),
      .e_rs        (e_rs),
      .e_rt        (e_rt),
      .e_rs_in     (e_rs_in),
      .e_rt_in     (e_rt_in),
      .stall       (stall),
      .d_rs_val    (d_rs_val),
      .d_rt_val    (d_rt_val),
      .e_rs_val    (e_rs_val),
      .e_rt_val    (e_rt_val)
`ifdef HAZARD_STAT_EN
      ,
      .stall_count (stall_count)
`endif
   );

   // 10 time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value with its expected value
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Drive the E-stage write-back record
   task automatic applyStimulus(input logic [4:0] adr, input logic [31:0] data,
                                input logic [4:0] tnew);
      e_regw_adr  = adr;
      e_reg_write = data;
      e_tnew      = tnew;
   endtask

   // Advance one clock edge and settle away from it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      applyStimulus(5'd0, 32'd0, 5'd0);
      m_rdata = 32'd0;
      d_rs = 5'd0; d_rt = 5'd0;
      d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
      d_rs_rf = 32'd0; d_rt_rf = 32'd0;
      e_rs = 5'd0; e_rt = 5'd0;
      e_rs_in = 32'd0; e_rt_in = 32'd0;

      // Reset held for two edges
      step();
      step();
      reset = 1'b1;
      d_rs = 5'd5; d_rs_rf = 32'h11; d_tuse_rs = 2'd0;
      e_rs = 5'd5; e_rs_in = 32'h77;
      #1;
      checkOutput("reset_stall", {31'd0, stall}, 32'd0);
      checkOutput("reset_d_rs", d_rs_val, 32'h11);
      checkOutput("reset_e_rs", e_rs_val, 32'h77);
`ifdef HAZARD_STAT_EN
      checkOutput("reset_count", stall_count, 32'd0);
`endif

      // ALU forward: E {8, 0x1234, tnew 1}
      applyStimulus(5'd8, 32'h1234, 5'd1);
      d_rs = 5'd8; d_tuse_rs = 2'd0;
      #1;
      checkOutput("alu_stall_t0", {31'd0, stall}, 32'd1);
      d_tuse_rs = 2'd1;
      #1;
      checkOutput("alu_stall_t1", {31'd0, stall}, 32'd0);
      checkOutput("alu_d_rs_rf", d_rs_val, 32'h11);
      step();
      applyStimulus(5'd0, 32'd0, 5'd0);
      e_rs = 5'd8; d_tuse_rs = 2'd0;
      #1;
      checkOutput("alu_e_rs_m", e_rs_val, 32'h1234);
      checkOutput("alu_d_rs_m", d_rs_val, 32'h1234);
      checkOutput("alu_nostall_m", {31'd0, stall}, 32'd0);
      step();
      checkOutput("alu_e_rs_w", e_rs_val, 32'h1234);

      // Load-use: E {9, tnew 2}, D rt=9 Tuse 1
      d_rs = 5'd0; e_rs = 5'd0;
      applyStimulus(5'd9, 32'hDEAD, 5'd2);
      d_rt = 5'd9; d_tuse_rt = 2'd1; d_rt_rf = 32'h22;
      e_rt_in = 32'h33;
      #1;
      checkOutput("load_stall_c0", {31'd0, stall}, 32'd1);
      step();
      applyStimulus(5'd0, 32'd0, 5'd0);
      m_rdata = 32'hBEEF;
      e_rt = 5'd9;
      #1;
      checkOutput("load_stall_c1", {31'd0, stall}, 32'd0);
      checkOutput("load_d_rt_c1", d_rt_val, 32'h22);
      checkOutput("load_e_rt_c1", e_rt_val, 32'h33);
      step();
      m_rdata = 32'd0;
      #1;
      checkOutput("load_e_rt_c2", e_rt_val, 32'hBEEF);
      checkOutput("load_d_rt_c2", d_rt_val, 32'hBEEF);
      d_rt = 5'd0; e_rt = 5'd0; d_tuse_rt = 2'd3;

      // Priority: M {3, 0xB, 0}, then E {3, 0xA, 0}
      applyStimulus(5'd3, 32'hB, 5'd0);
      step();
      applyStimulus(5'd3, 32'hA, 5'd0);
      d_rs = 5'd3; d_tuse_rs = 2'd0; e_rs = 5'd3;
      #1;
      checkOutput("prio_d_rs_e", d_rs_val, 32'hA);
      checkOutput("prio_e_rs_m", e_rs_val, 32'hB);
      applyStimulus(5'd3, 32'hA, 5'd2);
      d_tuse_rs = 2'd1;
      #1;
      checkOutput("prio_e_stall", {31'd0, stall}, 32'd1);
      applyStimulus(5'd0, 32'hA, 5'd2);
      d_rs = 5'd0; d_tuse_rs = 2'd0; d_rs_rf = 32'h44;
      #1;
      checkOutput("zero_stall", {31'd0, stall}, 32'd0);
      checkOutput("zero_d_rs", d_rs_val, 32'h44);

      // Reset mid-load discards the pending load
      e_rs = 5'd0;
      applyStimulus(5'd9, 32'h0, 5'd2);
      step();
      applyStimulus(5'd0, 32'd0, 5'd0);
      m_rdata = 32'hCAFE;
      reset = 1'b0;
      step();
      reset = 1'b1;
      m_rdata = 32'd0;
      d_rt = 5'd9; d_tuse_rt = 2'd0; d_rt_rf = 32'h55;
      e_rt = 5'd9; e_rt_in = 32'h66;
      #1;
      checkOutput("rstld_stall", {31'd0, stall}, 32'd0);
      checkOutput("rstld_d_rt", d_rt_val, 32'h55);
      checkOutput("rstld_e_rt", e_rt_val, 32'h66);
      d_rt = 5'd0; e_rt = 5'd0; d_tuse_rt = 2'd3;

      // Three stalled edges, then reset
      applyStimulus(5'd4, 32'd0, 5'd2);
      d_rs = 5'd4; d_tuse_rs = 2'd1;
      #1;
      checkOutput("stat_stall", {31'd0, stall}, 32'd1);
      step();
      step();
      step();
      applyStimulus(5'd0, 32'd0, 5'd0);
      d_rs = 5'd0;
      #1;
`ifdef HAZARD_STAT_EN
      checkOutput("stat_count3", stall_count, 32'd3);
`endif
      reset = 1'b0;
      step();
      reset = 1'b1;
`ifdef HAZARD_STAT_EN
      checkOutput("stat_count_rst", stall_count, 32'd0);
`endif
      checkOutput("final_e_rs", e_rs_val, e_rs_in);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
